// File: rtl/accumulator_fp_9x16_bit.sv
// Sums nine signed fixed-point products plus a bias and saturates to N bits.
// Build option: ACCUMULATOR_RELU_EN clamps negative results to zero.
//
// state | meaning
// IDLE  | waiting for start; result holds the last value
// ARM   | one-cycle gap so the upstream busy can rise
// WAIT  | waiting for mult_busy to drop, then latch p1..p9
// ACC   | adds one latched product per cycle, p1 first
// DONE  | result registered, valid high for this one cycle
module accumulator_fp_9x16_bit #(
    parameter int Q = 12,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] p1,
    input  logic [N-1:0] p2,
    input  logic [N-1:0] p3,
    input  logic [N-1:0] p4,
    input  logic [N-1:0] p5,
    input  logic [N-1:0] p6,
    input  logic [N-1:0] p7,
    input  logic [N-1:0] p8,
    input  logic [N-1:0] p9,
    input  logic [N-1:0] bias,
    input  logic         start,
    input  logic         mult_busy,
    output logic [N-1:0] result,
    output logic         valid,
    output logic         busy
);

    localparam int AW = N + 4;

    // Q only names the binary point; integer addition is the same for any Q.
    if (Q >= N) begin : g_q_exceeds_width
    end

    typedef enum logic [2:0] {IDLE, ARM, WAIT, ACC, DONE} state_t;

    state_t        state;
    logic [N-1:0]  prod [9];
    logic [AW-1:0] acc;
    logic [3:0]    idx;

    logic [N-1:0]  prod_sel;
    logic [AW-1:0] acc_sum;
    logic [N-1:0]  sat;

    always_comb begin
        prod_sel = prod[idx];
        acc_sum  = acc + {{(AW-N){prod_sel[N-1]}}, prod_sel};
        // The sum fits when every bit above the N-bit sign position agrees.
        if ((&acc_sum[AW-1:N-1]) || !(|acc_sum[AW-1:N-1]))
            sat = acc_sum[N-1:0];
        else if (acc_sum[AW-1])
            sat = {1'b1, {(N-1){1'b0}}};
        else
            sat = {1'b0, {(N-1){1'b1}}};
`ifdef ACCUMULATOR_RELU_EN
        if (sat[N-1])
            sat = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            acc    <= '0;
            idx    <= '0;
            for (int i = 0; i < 9; i++)
                prod[i] <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= {{(AW-N){bias[N-1]}}, bias};
                        busy  <= 1'b1;
                        state <= ARM;
                    end
                end
                ARM: state <= WAIT;
                WAIT: begin
                    if (!mult_busy) begin
                        prod[0] <= p1;
                        prod[1] <= p2;
                        prod[2] <= p3;
                        prod[3] <= p4;
                        prod[4] <= p5;
                        prod[5] <= p6;
                        prod[6] <= p7;
                        prod[7] <= p8;
                        prod[8] <= p9;
                        idx     <= '0;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_sum;
                    idx <= idx + 4'd1;
                    if (idx == 4'd8) begin
                        result <= sat;
                        valid  <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_fp_9x16_bit.sv
// Scoreboard bench for accumulator_fp_9x16_bit: expected sums are queued at
// start and compared when valid fires; latency and busy are checked per op.
module tb_accumulator_fp_9x16_bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pin [9];
    logic [15:0] bias = '0;
    logic        start = 1'b0;
    logic        mult_busy = 1'b0;
    logic [15:0] result;
    logic        valid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] sb [$];
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    accumulator_fp_9x16_bit #(.Q(12), .N(16)) dut (
        .clk(clk), .rst(rst),
        .p1(pin[0]), .p2(pin[1]), .p3(pin[2]), .p4(pin[3]), .p5(pin[4]),
        .p6(pin[5]), .p7(pin[6]), .p8(pin[7]), .p9(pin[8]),
        .bias(bias), .start(start), .mult_busy(mult_busy),
        .result(result), .valid(valid), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] b);
        int s;
        logic [15:0] r;
        s = $signed(b);
        for (int i = 0; i < 9; i++)
            s += $signed(pin[i]);
        if (s > 32767)       r = 16'h7FFF;
        else if (s < -32768) r = 16'h8000;
        else                 r = s[15:0];
`ifdef ACCUMULATOR_RELU_EN
        if (r[15]) r = 16'h0000;
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            chk("valid_one_cycle", {31'b0, prev_valid}, 32'd0);
            if (sb.size() == 0)
                chk("spurious_valid", {31'b0, valid}, 32'd0);
            else
                chk("result", {16'b0, result}, {16'b0, sb.pop_front()});
        end
        prev_valid <= valid;
    end

    // Call at posedge+1 of the start cycle S; returns at posedge+1 of the
    // cycle after DONE. mult_busy is high for cycles S+1..S+k.
    task automatic run_op(input logic [15:0] b, input int k, input logic [15:0] exp,
                          input logic extra_start);
        int lat, l;
        lat = -1;
        l = (k + 1 > 2) ? k + 1 : 2;
        bias = b;
        start = 1'b1;
        sb.push_back(exp);
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 0) chk("busy_idle", {31'b0, busy}, 32'd0);
            if (c == 1) chk("busy_armed", {31'b0, busy}, 32'd1);
            if (valid) begin
                lat = c;
                chk("busy_done", {31'b0, busy}, 32'd1);
            end
            @(posedge clk); #1;
            start = 1'b0;
            mult_busy = (c + 1 <= k);
            if (c == l)
                for (int i = 0; i < 9; i++) pin[i] = 16'($urandom);
            if (extra_start && c + 1 == l + 3) start = 1'b1;
        end
        chk("latency", lat, l + 10);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 9; i++) pin[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) pin[i] = 16'h0800;
        run_op(16'h1000, 1, 16'h5800, 1'b0);

        for (int i = 0; i < 9; i++) pin[i] = 16'h1000;
        run_op(16'h0000, 1, 16'h7FFF, 1'b0);

        for (int i = 0; i < 9; i++) pin[i] = 16'hF000;
`ifdef ACCUMULATOR_RELU_EN
        run_op(16'h0000, 0, 16'h0000, 1'b0);
`else
        run_op(16'h0000, 0, 16'h8000, 1'b0);
`endif

        for (int i = 0; i < 9; i++) pin[i] = 16'h0000;
        pin[0] = 16'h7FFF;
        pin[1] = 16'h8000;
        run_op(16'h0001, 6, 16'h0000, 1'b0);

        for (int i = 0; i < 9; i++) pin[i] = 16'h0123 + 16'(i);
        run_op(16'hFF00, 2, model(16'hFF00), 1'b1);

        for (int n = 0; n < 6; n++) begin
            logic [15:0] b;
            for (int i = 0; i < 9; i++) pin[i] = 16'($urandom);
            b = 16'($urandom);
            run_op(b, int'($urandom_range(0, 4)), model(b), 1'b0);
        end

        // Reset in the fourth accumulation cycle: no valid may follow.
        for (int i = 0; i < 9; i++) pin[i] = 16'h0400;
        bias = 16'h0100;
        start = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_result", {16'b0, result}, 32'd0);
        chk("midrst_valid", {31'b0, valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) pin[i] = 16'h0200;
        run_op(16'hF800, 0, model(16'hF800), 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
